// File: rtl/synth_seq_pkg.sv
// -----------------------------------------------------------------------------
// synth_seq_pkg
//   Shared types and sizing helpers for the frame sequencer.
//   seq_state_t      : sequencer FSM state {IDLE, RUN, DRAIN}
//   calc_x_width     : slot index width {voice, osc, env}
//   calc_n_slots     : slots swept per frame
//   calc_drain_cyc   : post-sweep mixer pipeline flush cycles
//   calc_cnt_width   : counter width for a given count (never below 1 bit)
// -----------------------------------------------------------------------------
package synth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Envelope-in-oscillator index is a single bit.
    localparam int OE_WIDTH = 1;

    function automatic int calc_x_width(input int voices, input int v_osc);
        return utils::clogb2(voices) + utils::clogb2(v_osc) + OE_WIDTH;
    endfunction

    function automatic int calc_n_slots(input int voices, input int v_osc, input int o_envs);
        return voices * v_osc * o_envs;
    endfunction

    function automatic int calc_drain_cyc(input int voices, input int v_osc);
        return v_osc * voices;
    endfunction

    function automatic int calc_cnt_width(input int n);
        int w;
        w = utils::clogb2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/utils.sv
// -----------------------------------------------------------------------------
// utils
//   Small shared helpers used by the synth engine RTL.
//   clogb2(n): number of bits needed to index n items, i.e. ceil(log2(n)).
//   Returns 0 for n <= 1.
// -----------------------------------------------------------------------------
package utils;

    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value - 1;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/synth_frame_sequencer_arbiter.sv
// -----------------------------------------------------------------------------
// seq_cfg_arbiter
//   Patch-parameter write grant plus overrun bookkeeping.
//   Optional feature macro: SEQ_OVERRUN_COUNT_EN (adds ovr_count).
//
//   Ports:
//     sCLK_XVXENVS  in   slot clock
//     reset         in   synchronous active-high reset
//     next_idle     in   sequencer will be IDLE after this edge
//     start_req     in   frame start accepted this cycle (sample_req && enable)
//     cfg_req       in   parameter writer wants access
//     ovr_event     in   sample_req arrived while busy (dropped)
//     ovr_clr       in   clear overrun (and ovr_count)
//     cfg_gnt       out  registered grant
//     overrun       out  sticky overrun flag
//     ovr_count     out  [15:0] saturating drop counter (macro only)
//
//   Handshake: cfg_req is a level request; cfg_gnt is a per-cycle permission.
//   The writer may write only in a cycle where cfg_gnt=1 and must accept the
//   grant falling at any edge. A frame start always beats a grant, so the
//   grant drops on the same edge the sweep begins and is never high while busy.
// -----------------------------------------------------------------------------
module seq_cfg_arbiter (
    input  logic        sCLK_XVXENVS,
    input  logic        reset,
    input  logic        next_idle,
    input  logic        start_req,
    input  logic        cfg_req,
    input  logic        ovr_event,
    input  logic        ovr_clr,
`ifdef SEQ_OVERRUN_COUNT_EN
    output logic [15:0] ovr_count,
`endif
    output logic        cfg_gnt,
    output logic        overrun
);

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            cfg_gnt <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cfg_gnt <= next_idle && cfg_req && !start_req;
            // A new drop outranks a simultaneous clear.
            if (ovr_event) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SEQ_OVERRUN_COUNT_EN
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            ovr_count <= 16'h0000;
        end else if (ovr_clr) begin
            // Clear and count in the same cycle leaves exactly one drop recorded.
            ovr_count <= ovr_event ? 16'h0001 : 16'h0000;
        end else if (ovr_event && (ovr_count != 16'hFFFF)) begin
            ovr_count <= ovr_count + 16'h0001;
        end
    end
`endif

endmodule

// File: rtl/synth_frame_sequencer.sv
// -----------------------------------------------------------------------------
// synth_frame_sequencer
//   Per-sample frame scheduler for the mixer/modulation datapath. On an
//   accepted sample request it sweeps xxxx over all N_SLOTS slots, then idles
//   DRAIN_CYC cycles for the mixer pipeline and pulses frame_done. Between
//   frames it grants the patch-parameter write path.
//   Optional feature macro: SEQ_OVERRUN_COUNT_EN (adds ovr_count[15:0]).
//
//   Ports:
//     sCLK_XVXENVS  in   slot clock
//     reset         in   synchronous active-high reset
//     enable        in   permits starting new frames
//     sample_req    in   single-cycle frame start request
//     xxxx          out  [X_WIDTH-1:0] slot index {voice, osc, env}
//     xxxx_zero     out  high while xxxx==0 in RUN
//     slot_valid    out  high in every RUN cycle
//     frame_done    out  one-cycle pulse as the sequencer returns to IDLE
//     busy          out  high in RUN or DRAIN
//     cfg_req       in   parameter writer wants access
//     cfg_gnt       out  access granted for this cycle
//     overrun       out  sticky: sample_req arrived while busy
//     ovr_count     out  [15:0] dropped request count (macro only)
//     ovr_clr       in   clears overrun / ovr_count
//
//   Every output is a register loaded from the next-state values, so the first
//   slot appears one cycle after the accepted request.
// -----------------------------------------------------------------------------
module synth_frame_sequencer
    import synth_seq_pkg::*;
#(
    parameter int VOICES = 32,
    parameter int V_OSC  = 8,
    parameter int O_ENVS = 2,
    parameter int X_WIDTH = calc_x_width(VOICES, V_OSC)
) (
    input  logic               sCLK_XVXENVS,
    input  logic               reset,
    input  logic               enable,
    input  logic               sample_req,
    output logic [X_WIDTH-1:0] xxxx,
    output logic               xxxx_zero,
    output logic               slot_valid,
    output logic               frame_done,
    output logic               busy,
    input  logic               cfg_req,
    output logic               cfg_gnt,
    output logic               overrun,
`ifdef SEQ_OVERRUN_COUNT_EN
    output logic [15:0]        ovr_count,
`endif
    input  logic               ovr_clr
);

    localparam int N_SLOTS   = calc_n_slots(VOICES, V_OSC, O_ENVS);
    localparam int DRAIN_CYC = calc_drain_cyc(VOICES, V_OSC);
    localparam int D_WIDTH   = calc_cnt_width(DRAIN_CYC);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(N_SLOTS - 1);
    localparam logic [D_WIDTH-1:0] D_LAST = D_WIDTH'(DRAIN_CYC - 1);

    seq_state_t         state_q, state_d;
    logic [X_WIDTH-1:0] xxxx_d;
    logic [D_WIDTH-1:0] drain_q, drain_d;
    logic               frame_done_d;
    logic               start_req;
    logic               ovr_event;

    assign start_req = sample_req && enable;
    // Requests landing in RUN/DRAIN are dropped regardless of enable.
    assign ovr_event = sample_req && (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        xxxx_d       = xxxx;
        drain_d      = drain_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                xxxx_d  = '0;
                drain_d = '0;
                if (start_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xxxx == X_LAST) begin
                    state_d = DRAIN;
                    xxxx_d  = '0;
                end else begin
                    xxxx_d = xxxx + 1'b1;
                end
            end
            DRAIN: begin
                xxxx_d = '0;
                if (drain_q == D_LAST) begin
                    state_d      = IDLE;
                    drain_d      = '0;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                xxxx_d  = '0;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            state_q    <= IDLE;
            xxxx       <= '0;
            drain_q    <= '0;
            xxxx_zero  <= 1'b0;
            slot_valid <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            xxxx       <= xxxx_d;
            drain_q    <= drain_d;
            xxxx_zero  <= (state_d == RUN) && (xxxx_d == '0);
            slot_valid <= (state_d == RUN);
            frame_done <= frame_done_d;
            busy       <= (state_d != IDLE);
        end
    end

    seq_cfg_arbiter u_arb (
        .sCLK_XVXENVS (sCLK_XVXENVS),
        .reset        (reset),
        .next_idle    (state_d == IDLE),
        .start_req    (start_req),
        .cfg_req      (cfg_req),
        .ovr_event    (ovr_event),
        .ovr_clr      (ovr_clr),
`ifdef SEQ_OVERRUN_COUNT_EN
        .ovr_count    (ovr_count),
`endif
        .cfg_gnt      (cfg_gnt),
        .overrun      (overrun)
    );

endmodule
